// File: rtl/hpdcache_fifo_serializer_if.sv
// ----------------------------------------------------------------------------
// hpdcache_fifo_serializer_if
// Bundles the FIFO drain side (rok/r/rdata/rlen) and the narrow beat side
// (valid/ready/beat/idx/last/busy) of the FIFO serializer.
//   slave  : used by the serializer (consumes FIFO entries, produces beats)
//   master : used by whatever sits around it (FIFO model + beat sink)
// Signal names keep the serializer-side _i/_o suffixes so waveforms line up
// with the serializer's own port list.
// ----------------------------------------------------------------------------
interface hpdcache_fifo_serializer_if #(
    parameter int unsigned BEAT_W = 64,
    parameter int unsigned NBEATS = 4,
    parameter int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1
);
    logic                     rok_i;
    logic                     r_o;
    logic [NBEATS*BEAT_W-1:0] rdata_i;
    logic [CNT_W-1:0]         rlen_i;
    logic                     valid_o;
    logic                     ready_i;
    logic [BEAT_W-1:0]        beat_o;
    logic [CNT_W-1:0]         idx_o;
    logic                     last_o;
    logic                     busy_o;

    modport slave (
        input  rok_i, rdata_i, rlen_i, ready_i,
        output r_o, valid_o, beat_o, idx_o, last_o, busy_o
    );

    modport master (
        output rok_i, rdata_i, rlen_i, ready_i,
        input  r_o, valid_o, beat_o, idx_o, last_o, busy_o
    );
endinterface

// File: rtl/hpdcache_fifo_serializer.sv
// ----------------------------------------------------------------------------
// hpdcache_fifo_serializer
// Drains one wide entry (NBEATS*BEAT_W bits) from a register FIFO and emits
// it as 1..NBEATS narrow beats on a valid/ready port. The beat count comes
// from the sideband length (beats minus one), clamped to NBEATS-1.
// Ports:
//   clk_i  : clock, all state on the rising edge
//   rst_i  : asynchronous active-high reset
//   io     : slave modport of hpdcache_fifo_serializer_if
//            rok_i/r_o/rdata_i/rlen_i  FIFO pop side
//            valid_o/ready_i           beat handshake
//            beat_o/idx_o/last_o       registered beat, its index, final flag
//            busy_o                    entry held (same as valid_o)
// ----------------------------------------------------------------------------
module hpdcache_fifo_serializer #(
    parameter int unsigned BEAT_W = 64,
    parameter int unsigned NBEATS = 4,
    parameter int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    hpdcache_fifo_serializer_if.slave  io
);
    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(NBEATS - 1);

    typedef enum logic {IDLE, SEND} state_e;

    state_e                        state_q, state_d;
    logic [NBEATS-1:0][BEAT_W-1:0] entry_q, entry_d;
    logic [CNT_W-1:0]              len_q, len_d;
    logic [CNT_W-1:0]              idx_q, idx_d;
    logic [BEAT_W-1:0]             beat_q, beat_d;
    logic [CNT_W-1:0]              len_eff;
    logic [CNT_W-1:0]              idx_inc;
    logic                          last;
    logic                          accept;
    logic                          pop;

    // Out-of-range lengths are clamped so the beat select can never run off
    // the end of the entry.
    assign len_eff = (io.rlen_i > LEN_MAX) ? LEN_MAX : io.rlen_i;
    assign idx_inc = idx_q + CNT_W'(1);

    // len_q only holds the clamped length, so idx_q never passes it.
    assign last   = (state_q == SEND) && (idx_q == len_q);
    assign accept = (state_q == SEND) && io.ready_i;

    // Pop while empty, or on the last beat's handshake so entries chain
    // without a bubble. ready_i is only looked at while an entry is held.
    assign pop = ~rst_i & io.rok_i & ((state_q == IDLE) | (accept & last));

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        len_d   = len_q;
        idx_d   = idx_q;
        beat_d  = beat_q;

        unique case (state_q)
            IDLE: ;
            SEND: begin
                if (accept && !last) begin
                    idx_d  = idx_inc;
                    beat_d = entry_q[idx_inc];
                end else if (accept && last) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A pop overrides the above: load the new entry and present beat 0.
        if (pop) begin
            state_d = SEND;
            entry_d = io.rdata_i;
            len_d   = len_eff;
            idx_d   = '0;
            beat_d  = io.rdata_i[BEAT_W-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            entry_q <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            beat_q  <= beat_d;
        end
    end

    assign io.r_o     = pop;
    assign io.valid_o = (state_q == SEND);
    assign io.busy_o  = (state_q == SEND);
    assign io.beat_o  = beat_q;
    assign io.idx_o   = idx_q;
    assign io.last_o  = last;

`ifndef SYNTHESIS
    a_pop_needs_rok : assert property (@(posedge clk_i) disable iff (rst_i)
        io.r_o |-> io.rok_i);

    a_hold_stable : assert property (@(posedge clk_i) disable iff (rst_i)
        (io.valid_o && !io.ready_i) |=>
        (io.valid_o && $stable(io.beat_o) && $stable(io.idx_o) && $stable(io.last_o)));
`endif

endmodule

// File: tb/tb_hpdcache_fifo_serializer.sv
// ----------------------------------------------------------------------------
// tb_hpdcache_fifo_serializer
// A FIFO model feeds entries; every pop expands the entry into its expected
// beats (clamped length, beat k = k-th slice) on a scoreboard queue. A
// separate monitor compares every presented beat with the queue head and
// retires it on handshake. Directed sequences check latency / no-bubble
// spans, backpressure and resets; a random phase follows.
// ----------------------------------------------------------------------------
module tb_hpdcache_fifo_serializer;
    localparam int BEAT_W = 64;
    localparam int NBEATS = 4;
    localparam int CNT_W  = 2;
    localparam int W      = NBEATS * BEAT_W;

    typedef struct {
        logic [W-1:0]     data;
        logic [CNT_W-1:0] len;
    } ent_t;

    typedef struct {
        logic [BEAT_W-1:0] beat;
        logic [CNT_W-1:0]  idx;
        logic              last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    hpdcache_fifo_serializer_if #(.BEAT_W(BEAT_W), .NBEATS(NBEATS)) bus ();

    hpdcache_fifo_serializer #(.BEAT_W(BEAT_W), .NBEATS(NBEATS)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .io    (bus)
    );

    ent_t fifo[$];
    exp_t sb[$];
    bit   rdy_script[$];
    int   total     = 0;
    int   bad       = 0;
    int   cyc       = 0;
    int   first_pop = -1;
    int   last_acc  = -1;
    bit   avail_all = 1'b1;
    bit   rdy_rand  = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic push_ent(input int len);
        ent_t e;
        e.data = rand_wide();
        e.len  = CNT_W'(len);
        fifo.push_back(e);
    endtask

    // Reference: entry of len L yields min(L, NBEATS-1)+1 beats in order.
    task automatic expect_entry(input ent_t e);
        int n;
        exp_t x;
        n = ((int'(e.len) > NBEATS - 1) ? NBEATS - 1 : int'(e.len)) + 1;
        for (int k = 0; k < n; k++) begin
            x.beat = e.data[k*BEAT_W +: BEAT_W];
            x.idx  = CNT_W'(k);
            x.last = (k == n - 1);
            sb.push_back(x);
        end
    endtask

    // One clock: drive at negedge, record a pop just before the posedge.
    task automatic cycle();
        ent_t e;
        @(negedge clk);
        cyc++;
        bus.rok_i = (fifo.size() != 0) && (avail_all || $urandom_range(0, 2) != 0);
        if (bus.rok_i) begin
            bus.rdata_i = fifo[0].data;
            bus.rlen_i  = fifo[0].len;
        end else begin
            bus.rdata_i = rand_wide();
            bus.rlen_i  = CNT_W'($urandom);
        end
        if (rdy_script.size() != 0) bus.ready_i = rdy_script.pop_front();
        else if (rdy_rand)          bus.ready_i = ($urandom_range(0, 3) != 0);
        else                        bus.ready_i = 1'b1;
        #6;
        if (bus.r_o) begin
            chk("pop_needs_rok", bus.rok_i, 1'b1);
            if (fifo.size() != 0) begin
                e = fifo.pop_front();
                expect_entry(e);
                if (first_pop < 0) first_pop = cyc;
            end
        end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        do begin
            cycle();
            n++;
        end while ((fifo.size() != 0 || sb.size() != 0 || bus.valid_o) && n < bound);
        total++;
        if (fifo.size() != 0 || sb.size() != 0 || bus.valid_o) begin
            bad++;
            $display("FAIL drain: still pending fifo=%0d beats=%0d valid=%0b after %0d cycles",
                     fifo.size(), sb.size(), bus.valid_o, n);
        end
    endtask

    task automatic start_test();
        first_pop = -1;
        last_acc  = -1;
    endtask

    // Monitor: valid must track whether beats are owed; each presented beat
    // must equal the scoreboard head whether or not it is accepted.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                chk("valid", bus.valid_o, sb.size() != 0);
                chk("busy", bus.busy_o, sb.size() != 0);
                if (bus.valid_o && sb.size() != 0) begin
                    chk("beat", bus.beat_o, sb[0].beat);
                    chk("idx", bus.idx_o, sb[0].idx);
                    chk("last", bus.last_o, sb[0].last);
                    if (bus.ready_i) begin
                        void'(sb.pop_front());
                        last_acc = cyc;
                    end
                end
            end
        end
    end

    initial begin
        // Reset with an entry offered: no pop may happen.
        bus.rok_i   = 1'b1;
        bus.ready_i = 1'b0;
        bus.rdata_i = rand_wide();
        bus.rlen_i  = '0;
        repeat (2) @(negedge clk);
        #6;
        chk("r_in_reset", bus.r_o, 1'b0);
        chk("valid_in_reset", bus.valid_o, 1'b0);
        bus.rok_i = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_valid", bus.valid_o, 1'b0);
        chk("rst_idx", bus.idx_o, '0);
        chk("rst_last", bus.last_o, 1'b0);
        chk("rst_beat", bus.beat_o, '0);

        // Single 4-beat entry: pop, then 4 contiguous beats.
        start_test();
        push_ent(3);
        drain(50);
        chk("span_4beat", last_acc - first_pop, 4);

        // Back-to-back 2-beat + 1-beat: 3 beats, no bubble.
        start_test();
        push_ent(1);
        push_ent(0);
        drain(50);
        chk("span_b2b", last_acc - first_pop, 3);

        // Backpressure for 5 cycles at idx 2; following entry must wait.
        start_test();
        push_ent(3);
        push_ent(0);
        rdy_script = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        drain(50);
        chk("span_stall", last_acc - first_pop, 10);

        // Single-beat entries stream one per cycle.
        start_test();
        repeat (6) push_ent(0);
        drain(50);
        chk("span_stream", last_acc - first_pop, 6);

        // Oversized length request (truncated to the field) clamps to 4 beats.
        start_test();
        push_ent(7);
        drain(50);
        chk("span_clamp", last_acc - first_pop, 4);

        // Reset mid-entry at idx 1: outputs drop at once, nothing replayed.
        start_test();
        push_ent(3);
        repeat (3) cycle();
        rst = 1'b1;
        #1;
        chk("midrst_valid", bus.valid_o, 1'b0);
        chk("midrst_idx", bus.idx_o, '0);
        chk("midrst_r", bus.r_o, 1'b0);
        #1;
        rst = 1'b0;
        sb.delete();
        start_test();
        push_ent(2);
        drain(50);
        chk("span_after_rst", last_acc - first_pop, 3);

        // Random phase: random availability, backpressure, lengths, data.
        avail_all = 1'b0;
        rdy_rand  = 1'b1;
        for (int i = 0; i < 300; i++) push_ent($urandom_range(0, 3));
        drain(8000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
